// File: rtl/mem_arb_pkg.sv
// Shared state encoding and requester identifiers for the memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  localparam logic REQ_ID_IMEM = 1'b0;
  localparam logic REQ_ID_DMEM = 1'b1;

  function automatic arb_state_e busyStateFor(input logic reqId);
    return (reqId == REQ_ID_DMEM) ? BUSY_D : BUSY_I;
  endfunction

endpackage

// File: rtl/mem_arb_req_reg.sv
// Holds the winning request's address and write controls for the whole downstream transaction.
module mem_arb_req_reg #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int STRB_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              capture_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              wen_i,
  input  logic [STRB_W-1:0] strb_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              wen_o,
  output logic [STRB_W-1:0] strb_o,
  output logic [DATA_W-1:0] wdata_o
);

  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [STRB_W-1:0] strb_q;
  logic [DATA_W-1:0] wdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      wen_q   <= 1'b0;
      strb_q  <= '0;
      wdata_q <= '0;
    end else if (capture_i) begin
      addr_q  <= addr_i;
      wen_q   <= wen_i;
      strb_q  <= strb_i;
      wdata_q <= wdata_i;
    end
  end

  assign addr_o  = addr_q;
  assign wen_o   = wen_q;
  assign strb_o  = strb_q;
  assign wdata_o = wdata_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (imem/dmem) arbiter with one outstanding downstream transaction.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is dmem priority with an imem starvation guard.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_ADDR_W = 64,
  parameter int MEM_DATA_W = 64,
  parameter int MEM_STRB_W = 8,
  parameter int STARVE_LIM = 4
) (
  input  logic                  f_clk,
  input  logic                  g_resetn,
  input  logic                  imem_req,
  input  logic [MEM_ADDR_W-1:0] imem_addr,
  input  logic                  imem_wen,
  input  logic [MEM_STRB_W-1:0] imem_strb,
  input  logic [MEM_DATA_W-1:0] imem_wdata,
  output logic                  imem_gnt,
  output logic                  imem_err,
  output logic [MEM_DATA_W-1:0] imem_rdata,
  input  logic                  dmem_req,
  input  logic [MEM_ADDR_W-1:0] dmem_addr,
  input  logic                  dmem_wen,
  input  logic [MEM_STRB_W-1:0] dmem_strb,
  input  logic [MEM_DATA_W-1:0] dmem_wdata,
  output logic                  dmem_gnt,
  output logic                  dmem_err,
  output logic [MEM_DATA_W-1:0] dmem_rdata,
  output logic                  mem_req,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [MEM_STRB_W-1:0] mem_strb,
  output logic [MEM_DATA_W-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_err,
  input  logic [MEM_DATA_W-1:0] mem_rdata
);

  arb_state_e            state_q, state_d;
  logic                  winnerId;
  logic                  capture;
  logic                  busy;
  logic [MEM_ADDR_W-1:0] selAddr, regAddr;
  logic                  selWen, regWen;
  logic [MEM_STRB_W-1:0] selStrb, regStrb;
  logic [MEM_DATA_W-1:0] selWdata, regWdata;

  always_comb begin
    if (winnerId == REQ_ID_DMEM) begin
      selAddr  = dmem_addr;
      selWen   = dmem_wen;
      selStrb  = dmem_strb;
      selWdata = dmem_wdata;
    end else begin
      selAddr  = imem_addr;
      selWen   = imem_wen;
      selStrb  = imem_strb;
      selWdata = imem_wdata;
    end
  end

  mem_arb_req_reg #(
    .ADDR_W (MEM_ADDR_W),
    .DATA_W (MEM_DATA_W),
    .STRB_W (MEM_STRB_W)
  ) uReqReg (
    .clk_i     (f_clk),
    .rst_ni    (g_resetn),
    .capture_i (capture),
    .addr_i    (selAddr),
    .wen_i     (selWen),
    .strb_i    (selStrb),
    .wdata_i   (selWdata),
    .addr_o    (regAddr),
    .wen_o     (regWen),
    .strb_o    (regStrb),
    .wdata_o   (regWdata)
  );

`ifdef MEM_ARB_RR_EN
  logic lastGnt_q, lastGnt_d;

  // On a tie the requester granted most recently yields.
  always_comb begin
    if (imem_req && dmem_req) begin
      winnerId = (lastGnt_q == REQ_ID_DMEM) ? REQ_ID_IMEM : REQ_ID_DMEM;
    end else begin
      winnerId = dmem_req ? REQ_ID_DMEM : REQ_ID_IMEM;
    end
  end

  always_comb begin
    lastGnt_d = lastGnt_q;
    if (imem_gnt) begin
      lastGnt_d = REQ_ID_IMEM;
    end else if (dmem_gnt) begin
      lastGnt_d = REQ_ID_DMEM;
    end
  end

  always_ff @(posedge f_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      lastGnt_q <= REQ_ID_DMEM;
    end else begin
      lastGnt_q <= lastGnt_d;
    end
  end
`else
  localparam int              CNT_W      = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIM);

  logic [CNT_W-1:0] starveCnt_q, starveCnt_d;

  always_comb begin
    if (imem_req && dmem_req) begin
      winnerId = (starveCnt_q == STARVE_MAX) ? REQ_ID_IMEM : REQ_ID_DMEM;
    end else begin
      winnerId = dmem_req ? REQ_ID_DMEM : REQ_ID_IMEM;
    end
  end

  // Counts dmem grants that imem sat through; any gap in imem_req forgives the debt.
  always_comb begin
    starveCnt_d = starveCnt_q;
    if (!imem_req || imem_gnt) begin
      starveCnt_d = '0;
    end else if (dmem_gnt && (starveCnt_q != STARVE_MAX)) begin
      starveCnt_d = starveCnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge f_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      starveCnt_q <= '0;
    end else begin
      starveCnt_q <= starveCnt_d;
    end
  end
`endif

  always_ff @(posedge f_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A requester that dropped its request mid-transaction sees no grant.
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    busy     = 1'b0;
    imem_gnt = 1'b0;
    dmem_gnt = 1'b0;
    case (state_q)
      IDLE: begin
        if (imem_req || dmem_req) begin
          capture = 1'b1;
          state_d = busyStateFor(winnerId);
        end
      end
      BUSY_I: begin
        busy = 1'b1;
        if (mem_gnt) begin
          imem_gnt = imem_req;
          state_d  = IDLE;
        end
      end
      BUSY_D: begin
        busy = 1'b1;
        if (mem_gnt) begin
          dmem_gnt = dmem_req;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req    = busy;
  assign mem_addr   = busy ? regAddr : '0;
  assign mem_wen    = busy & regWen;
  assign mem_strb   = busy ? regStrb : '0;
  assign mem_wdata  = busy ? regWdata : '0;

  assign imem_err   = imem_gnt & mem_err;
  assign imem_rdata = imem_gnt ? mem_rdata : '0;
  assign dmem_err   = dmem_gnt & mem_err;
  assign dmem_rdata = dmem_gnt ? mem_rdata : '0;

endmodule
